// File: rtl/mem_pkg.sv
// Shared memory-side encodings for the load extenders and store serializer.
// Size codes, serializer state encoding and size helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic logic [2:0] beats_of(input logic [1:0] sz);
        logic [2:0] n;
        n = 3'd0;
        unique case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Illegal size counts as a reject alongside misalignment.
    function automatic logic is_reject(input logic [1:0] sz,
                                       input logic [1:0] lo);
        logic r;
        r = 1'b0;
        unique case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            SZ_WORD: r = |lo;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Little-endian byte lane select for the store serializer.
// Picks byte k of a 32-bit word.
module store_byte_sel (
    input  logic [31:0] data_i,
    input  logic [1:0]  idx_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = data_i[7:0];
        unique case (idx_i)
            2'd0: byte_o = data_i[7:0];
            2'd1: byte_o = data_i[15:8];
            2'd2: byte_o = data_i[23:16];
            2'd3: byte_o = data_i[31:24];
            default: byte_o = data_i[7:0];
        endcase
    end

endmodule

// File: rtl/store_serializer.sv
// MEM-stage store narrower: 32-bit store split into 1/2/4 byte beats.
// Misaligned or illegal stores pulse misalign and issue no beats.
module store_serializer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_byte,
    output logic              busy,
    output logic              done,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        last_q;
    logic [1:0]        k_q;
    logic              done_q;
    logic              misalign_q;

    logic accept, reject, legal, hs, last_beat;
    logic [2:0] n_beats;

    assign accept    = req_valid && req_ready;
    assign reject    = is_reject(req_size, req_addr[1:0]);
    assign legal     = accept && !reject;
    assign hs        = mem_valid && mem_ready;
    assign last_beat = (k_q == last_q);
    assign n_beats   = beats_of(req_size);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (legal) state_d = ST_SEND;
            ST_SEND: if (hs && last_beat) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        mem_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_SEND: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            done_q     <= hs && last_beat;
            misalign_q <= accept && reject;
            if (legal) begin
                addr_q <= req_addr;
                data_q <= req_data;
                last_q <= 2'(n_beats - 3'd1);
                k_q    <= '0;
            end else if (hs) begin
                k_q <= k_q + 2'd1;
            end
        end
    end

    // Beat address is recomputed from k so stalls hold it stable for free.
    assign mem_addr = addr_q + ADDR_W'(k_q);
    assign done     = done_q;
    assign misalign = misalign_q;

    store_byte_sel u_sel (
        .data_i (data_q),
        .idx_i  (k_q),
        .byte_o (mem_byte)
    );

endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench for store_serializer.
// Directed cases from the store rules, then randomized stores.
module tb_store_serializer;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_byte;
    logic        busy;
    logic        done;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    store_serializer #(.ADDR_W(32)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_byte  (mem_byte),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge; leaves time at #1 after the done/reject edge.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input int stall0,
                             input bit rnd);
        bit    rej;
        int    n;
        int    i;
        int    st;
        int    budget;
        logic [31:0] ea;
        logic [31:0] eb;
        rej = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
              (sz == 2'd2 && a % 4 != 0);
        n = 1 << sz;
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        if (rej) begin
            chk("misalign_pulse", {31'd0, misalign}, 32'd1);
            chk("rej_mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("rej_done", {31'd0, done}, 32'd0);
            chk("rej_req_ready", {31'd0, req_ready}, 32'd1);
            return;
        end
        i = 0;
        st = 0;
        budget = 0;
        while (i < n && budget < 64) begin
            ea = a + i;
            eb = (d >> (8 * i)) & 32'hFF;
            chk("beat_valid", {31'd0, mem_valid}, 32'd1);
            chk("beat_busy", {31'd0, busy}, 32'd1);
            chk("beat_ready", {31'd0, req_ready}, 32'd0);
            chk("beat_addr", mem_addr, ea);
            chk("beat_byte", {24'd0, mem_byte}, eb);
            chk("beat_done", {31'd0, done}, 32'd0);
            chk("beat_misalign", {31'd0, misalign}, 32'd0);
            if (i == 0 && st < stall0) begin
                mem_ready = 1'b0;
                st++;
            end else if (rnd) begin
                mem_ready = ($urandom_range(0, 2) != 0);
            end else begin
                mem_ready = 1'b1;
            end
            tick();
            if (mem_ready) i++;
            budget++;
        end
        chk("beat_budget", {31'd0, (i == n)}, 32'd1);
        mem_ready = 1'b1;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic idle_check();
        tick();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_misalign", {31'd0, misalign}, 32'd0);
        chk("idle_mem_valid", {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        clrn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_byte", {24'd0, mem_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        clrn = 1'b1;
        tick();

        run_store(32'h100, 32'hA1B2C3D4, 2'd2, 0, 1'b0);
        idle_check();
        run_store(32'h202, 32'hFFFF1234, 2'd1, 2, 1'b0);
        idle_check();
        run_store(32'h7, 32'h000000EE, 2'd0, 0, 1'b0);
        run_store(32'h300, 32'h5566AABB, 2'd2, 0, 1'b0);
        run_store(32'h102, 32'h11223344, 2'd2, 0, 1'b0);
        run_store(32'h101, 32'h11223344, 2'd1, 0, 1'b0);
        run_store(32'h100, 32'h11223344, 2'd3, 0, 1'b0);
        idle_check();
        run_store(32'hFFFFFFFC, 32'h0A0B0C0D, 2'd2, 0, 1'b0);
        idle_check();

        req_valid = 1'b1;
        req_addr  = 32'h400;
        req_data  = 32'hCAFEF00D;
        req_size  = 2'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_addr", mem_addr, 32'h402);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        run_store(32'h55, 32'h000000A5, 2'd0, 0, 1'b0);
        idle_check();

        for (int t = 0; t < 40; t++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 9) < 7) ra = ra & ~32'h3;
            run_store(ra, $urandom, rs, $urandom_range(0, 2), 1'b1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
